avalon_mem_arbiter: RTL

AVALON_MEM_ARBITER -- requirements
Module: avalon_mem_arbiter

---
 rtl/arb_pkg.sv | 22 ++
 rtl/avalon_mem_arbiter_if.sv | 25 ++
 rtl/arb_priority_sel.sv | 30 +++
 rtl/avalon_mem_arbiter.sv | 100 ++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types for the two-master Avalon memory arbiter: FSM states, owner
// encoding and the debug snapshot exported by the top.
package arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    localparam logic OWNER_M0 = 1'b0;
    localparam logic OWNER_M1 = 1'b1;

    localparam int CNT_W = 5;

    typedef struct packed {
        state_e           state;
        logic             owner;
        logic             last_owner;
        logic [CNT_W-1:0] cnt;
    } dbg_t;

endpackage

// File: rtl/avalon_mem_arbiter_if.sv
// Avalon-MM request/response bundle; the master modport drives the request,
// the slave modport answers with readdata and waitrequest.
interface avalon_mem_arbiter_if;

    // A request is live while read or write is high; the master holds every
    // request field stable until it samples waitrequest low on a clock edge.
    logic        read;
    logic        write;
    logic [31:0] addr;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;
    logic        waitrequest;

    modport master (
        output read, write, addr, writedata, byteenable,
        input  readdata, waitrequest
    );

    modport slave (
        input  read, write, addr, writedata, byteenable,
        output readdata, waitrequest
    );

endinterface

// File: rtl/arb_priority_sel.sv
// Picks the winning master when requests arrive in IDLE.
// ARB_ROUND_ROBIN_EN: ties go to the master other than last_owner; otherwise m1 wins ties.
module arb_priority_sel
    import arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_owner,
    output logic winner
);

    always_comb begin
        winner = OWNER_M0;
        if (req0 && req1) begin
`ifdef ARB_ROUND_ROBIN_EN
            winner = ~last_owner;
`else
            winner = OWNER_M1;
`endif
        end else if (req1) begin
            winner = OWNER_M1;
        end
    end

`ifndef ARB_ROUND_ROBIN_EN
    logic unused_last_owner;
    assign unused_last_owner = last_owner;
`endif

endmodule

// File: rtl/avalon_mem_arbiter.sv
// Two-master (m0 instruction, m1 data) arbiter in front of one Avalon memory
// slave, with per-transfer timeout. Tie policy selected by ARB_ROUND_ROBIN_EN.
module avalon_mem_arbiter
    import arb_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    avalon_mem_arbiter_if.slave  m0,
    avalon_mem_arbiter_if.slave  m1,
    avalon_mem_arbiter_if.master s,
    output logic                 timeout_err,
    output dbg_t                 dbg_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e           state_q;
    logic             owner_q;
    logic             last_owner_q;
    logic [CNT_W-1:0] cnt_q;
    logic             timeout_err_q;

    logic        req0, req1, winner_d;
    logic        busy, own_read, own_write, own_req;
    logic [31:0] own_addr, own_wdata;
    logic [3:0]  own_be;

    assign req0 = m0.read | m0.write;
    assign req1 = m1.read | m1.write;

    arb_priority_sel u_sel (
        .req0       (req0),
        .req1       (req1),
        .last_owner (last_owner_q),
        .winner     (winner_d)
    );

    assign busy      = (state_q == BUSY);
    assign own_read  = (owner_q == OWNER_M1) ? m1.read       : m0.read;
    assign own_write = (owner_q == OWNER_M1) ? m1.write      : m0.write;
    assign own_addr  = (owner_q == OWNER_M1) ? m1.addr       : m0.addr;
    assign own_wdata = (owner_q == OWNER_M1) ? m1.writedata  : m0.writedata;
    assign own_be    = (owner_q == OWNER_M1) ? m1.byteenable : m0.byteenable;
    assign own_req   = own_read | own_write;

    // Read takes precedence when a master raises both strobes.
    assign s.read       = busy & own_read;
    assign s.write      = busy & own_write & ~own_read;
    assign s.addr       = busy ? own_addr  : 32'h0;
    assign s.writedata  = busy ? own_wdata : 32'h0;
    assign s.byteenable = busy ? own_be    : 4'h0;

    assign m0.waitrequest = ~(busy && owner_q == OWNER_M0) | s.waitrequest;
    assign m1.waitrequest = ~(busy && owner_q == OWNER_M1) | s.waitrequest;
    assign m0.readdata    = s.readdata;
    assign m1.readdata    = s.readdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            owner_q       <= OWNER_M0;
            last_owner_q  <= OWNER_M1;
            cnt_q         <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            timeout_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req0 || req1) begin
                        owner_q <= winner_d;
                        cnt_q   <= '0;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    // Completion wins over the timeout in the same cycle.
                    if (!own_req) begin
                        state_q <= IDLE;
                    end else if (!s.waitrequest) begin
                        state_q      <= IDLE;
                        last_owner_q <= owner_q;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q       <= IDLE;
                        timeout_err_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign timeout_err = timeout_err_q;
    assign dbg_o       = '{state: state_q, owner: owner_q,
                           last_owner: last_owner_q, cnt: cnt_q};

endmodule
